// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter sharing one fifo_sync write port.
// A grant covers a whole burst. The burst ends on req_last, or when MAX_BURST
// beats have passed, or when the owner stalls for HOLD_TIMEOUT cycles. A new
// burst starts only when the FIFO reports at least START_THRESH free spots.
module fifo_wr_arb #(
  parameter int NUM_REQ      = 4,
  parameter int WIDTH        = 32,
  parameter int LENGTH       = 16,
  parameter int MAX_BURST    = 8,
  parameter int START_THRESH = 4,
  parameter int HOLD_TIMEOUT = 16,
  localparam int IDW         = $clog2(NUM_REQ),
  localparam int SPW         = $clog2(LENGTH + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_last,
  input  logic [WIDTH-1:0]   req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output logic               fifo_wr_en,
  output logic [WIDTH-1:0]   fifo_wr_data,
  input  logic               fifo_wr_ready,
  input  logic [SPW-1:0]     fifo_spots,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic               abort
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam int ICW = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [1:0]     r_rst_sync;
  logic           w_rst_n;
  logic [0:0]     r_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_grant_id;
  logic [BCW-1:0] r_beat_cnt;
  logic [ICW-1:0] r_idle_cnt;

  logic           w_in_burst;
  logic           w_owner_valid;
  logic           w_owner_last;
  logic           w_beat;
  logic           w_burst_end;
  logic           w_timeout;
  logic           w_spots_ok;
  logic           w_found;
  logic [IDW-1:0] w_pick;
  logic [IDW-1:0] w_next_ptr;

  // Reset synchronizer: assertion reaches the core at once, release waits two clock edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_in_burst    = (r_state == ST_BURST);
  assign w_owner_valid = req_valid[r_grant_id];
  assign w_owner_last  = req_last[r_grant_id];
  assign w_beat        = w_in_burst & w_owner_valid & fifo_wr_ready;
  assign w_burst_end   = w_beat & (w_owner_last | (r_beat_cnt == BCW'(MAX_BURST - 1)));
  // A full FIFO with a valid owner is not a stall; only a missing req_valid counts.
  assign w_timeout     = w_in_burst & ~w_owner_valid & (r_idle_cnt == ICW'(HOLD_TIMEOUT - 1));
  assign w_spots_ok    = (fifo_spots >= SPW'(START_THRESH));
  assign w_next_ptr    = (r_grant_id == IDW'(NUM_REQ - 1)) ? IDW'(0) : (r_grant_id + IDW'(1));

  // Round-robin search: first valid requester at or after r_rr_ptr, wrapping.
  always_comb begin
    logic [IDW-1:0] v_idx;
    w_found = 1'b0;
    w_pick  = IDW'(0);
    v_idx   = IDW'(0);
    for (int i = 0; i < NUM_REQ; i++) begin
      v_idx = IDW'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_pick  = v_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Burst state machine with beat and stall counters.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= IDW'(0);
      r_grant_id <= IDW'(0);
      r_beat_cnt <= BCW'(0);
      r_idle_cnt <= ICW'(0);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found && w_spots_ok) begin
            r_state    <= ST_BURST;
            r_grant_id <= w_pick;
            r_beat_cnt <= BCW'(0);
            r_idle_cnt <= ICW'(0);
          end
        end
        ST_BURST: begin
          if (w_burst_end || w_timeout) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_beat_cnt <= BCW'(0);
            r_idle_cnt <= ICW'(0);
          end else begin
            if (w_beat) begin
              r_beat_cnt <= r_beat_cnt + BCW'(1);
            end
            if (w_owner_valid) begin
              r_idle_cnt <= ICW'(0);
            end else begin
              r_idle_cnt <= r_idle_cnt + ICW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Only the owner sees the FIFO's ready; everything is forced to 0 outside a burst.
  always_comb begin
    req_ready = '0;
    if (w_in_burst) begin
      req_ready[r_grant_id] = fifo_wr_ready;
    end else begin
      req_ready = '0;
    end
  end

  // Write data is the owner's data during a burst, 0 otherwise.
  always_comb begin
    fifo_wr_data = '0;
    if (w_in_burst) begin
      fifo_wr_data = req_data[r_grant_id];
    end else begin
      fifo_wr_data = '0;
    end
  end

  assign fifo_wr_en  = w_beat;
  assign grant_valid = w_in_burst;
  assign grant_id    = r_grant_id;
  assign abort       = w_timeout;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed vector table plus hand-written multi-cycle sequences.
module tb_fifo_wr_arb;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data [4];
  logic [3:0]  req_ready;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_wr_ready;
  logic [4:0]  fifo_spots;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        abort;

  int n_pass  = 0;
  int n_total = 0;

  fifo_wr_arb dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_ready(fifo_wr_ready),
    .fifo_spots   (fifo_spots),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .abort        (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] l;
    logic       rdy;
    logic [4:0] sp;
    logic [3:0] er;
    logic       ee;
    logic       eg;
    logic [1:0] gid;
    logic       ea;
  } vec_t;

  vec_t tbl [31];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                              input logic [4:0] sp, input logic [3:0] er, input logic ee,
                              input logic eg, input logic [1:0] gid, input logic ea);
    vec_t t;
    t.v = v; t.l = l; t.rdy = rdy; t.sp = sp;
    t.er = er; t.ee = ee; t.eg = eg; t.gid = gid; t.ea = ea;
    return t;
  endfunction

  function automatic logic [31:0] exp_data(input logic gv, input logic [1:0] gid, input int tag);
    logic [7:0] hi;
    hi = 8'hD0 + {6'd0, gid};
    return gv ? {hi, 24'(tag)} : 32'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       input logic [4:0] sp, input int tag);
    req_valid     = v;
    req_last      = l;
    fifo_wr_ready = rdy;
    fifo_spots    = sp;
    for (int i = 0; i < 4; i++) begin
      req_data[i] = {8'hD0 + 8'(i), 24'(tag)};
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_ready"}, {28'd0, req_ready}, 32'd0);
    chk({nm, "_en"},    {31'd0, fifo_wr_en}, 32'd0);
    chk({nm, "_gv"},    {31'd0, grant_valid}, 32'd0);
    chk({nm, "_abort"}, {31'd0, abort}, 32'd0);
    chk({nm, "_data"},  fifo_wr_data, 32'd0);
  endtask

  // Global time bound so the run always ends.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tag;
    int r1, r3, cur_own, cur_len, n_ab, cyc;
    logic in_b, seen;
    int own_q[$];
    int len_q[$];
    int exp_own [6];
    int exp_len [6];

    // Vector table: sequential cycles; comments give the round-robin pointer afterwards.
    tbl[0]  = mk(4'b0100, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // idle, picks 2
    tbl[1]  = mk(4'b0100, 4'b0000, 1'b1, 5'd16, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
    tbl[2]  = mk(4'b0100, 4'b0000, 1'b1, 5'd16, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
    tbl[3]  = mk(4'b0100, 4'b0100, 1'b1, 5'd16, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0); // end, rr=3
    tbl[4]  = mk(4'b0000, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[5]  = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // picks 3
    tbl[6]  = mk(4'b1111, 4'b1111, 1'b1, 5'd16, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0); // wrap, rr=0
    tbl[7]  = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[8]  = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
    tbl[9]  = mk(4'b1111, 4'b1111, 1'b1, 5'd16, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
    tbl[10] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[11] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    tbl[12] = mk(4'b1111, 4'b1111, 1'b1, 5'd16, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0);
    tbl[13] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[14] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
    tbl[15] = mk(4'b1111, 4'b1111, 1'b1, 5'd16, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0);
    tbl[16] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[17] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
    tbl[18] = mk(4'b1111, 4'b1111, 1'b1, 5'd16, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0);
    tbl[19] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[20] = mk(4'b1111, 4'b0000, 1'b1, 5'd16, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0);
    tbl[21] = mk(4'b1111, 4'b1111, 1'b1, 5'd16, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0); // rr=1
    tbl[22] = mk(4'b0001, 4'b0000, 1'b1, 5'd3,  4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // too few spots
    tbl[23] = mk(4'b0001, 4'b0000, 1'b1, 5'd3,  4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[24] = mk(4'b0001, 4'b0000, 1'b1, 5'd4,  4'b0000, 1'b0, 1'b0, 2'd0, 1'b0); // threshold met
    tbl[25] = mk(4'b0001, 4'b0001, 1'b1, 5'd4,  4'b0001, 1'b1, 1'b1, 2'd0, 1'b0); // rr=1
    tbl[26] = mk(4'b0000, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[27] = mk(4'b0010, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    tbl[28] = mk(4'b0010, 4'b0000, 1'b0, 5'd16, 4'b0000, 1'b0, 1'b1, 2'd1, 1'b0); // FIFO full
    tbl[29] = mk(4'b0010, 4'b0010, 1'b1, 5'd16, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0); // rr=2
    tbl[30] = mk(4'b0000, 4'b0000, 1'b1, 5'd16, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset state.
    reset_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b1, 5'd16, 0);
    #12;
    check_idle("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_idle("after_reset");
    chk("after_reset_gid", {30'd0, grant_id}, 32'd0);

    // Table-driven vectors.
    tag = 100;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      tag = tag + 1;
      drive(tbl[k].v, tbl[k].l, tbl[k].rdy, tbl[k].sp, tag);
      #1;
      chk($sformatf("v%0d_ready", k), {28'd0, req_ready}, {28'd0, tbl[k].er});
      chk($sformatf("v%0d_en", k),    {31'd0, fifo_wr_en}, {31'd0, tbl[k].ee});
      chk($sformatf("v%0d_gv", k),    {31'd0, grant_valid}, {31'd0, tbl[k].eg});
      chk($sformatf("v%0d_abort", k), {31'd0, abort}, {31'd0, tbl[k].ea});
      chk($sformatf("v%0d_data", k),  fifo_wr_data, exp_data(tbl[k].eg, tbl[k].gid, tag));
      if (tbl[k].eg) begin
        chk($sformatf("v%0d_gid", k), {30'd0, grant_id}, {30'd0, tbl[k].gid});
      end
    end

    // Req 1 streams 20 beats without last while req 3 sends three 1-beat packets (rr=2).
    exp_own = '{3, 1, 3, 1, 3, 1};
    exp_len = '{1, 8, 1, 8, 1, 4};
    r1 = 20; r3 = 3; in_b = 1'b0; cur_own = 0; cur_len = 0; n_ab = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      if (r1 == 0 && r3 == 0 && !in_b) break;
      @(negedge clk);
      drive({(r3 > 0), 1'b0, (r1 > 0), 1'b0}, 4'b1000, 1'b1, 5'd16, 500 + cyc);
      #1;
      n_ab = n_ab + int'(abort);
      if (fifo_wr_en) begin
        if (!in_b) begin
          in_b = 1'b1;
          cur_own = int'(grant_id);
          cur_len = 0;
        end
        cur_len++;
        if (req_ready[1]) r1--;
        if (req_ready[3]) r3--;
      end else if (!grant_valid && in_b) begin
        own_q.push_back(cur_own);
        len_q.push_back(cur_len);
        in_b = 1'b0;
      end
    end
    chk("stream_done_in_budget", {31'd0, (cyc < 300)}, 32'd1);
    chk("stream_nbursts", own_q.size(), 32'd6);
    for (int b = 0; b < 6; b++) begin
      if (b < own_q.size()) begin
        chk($sformatf("stream_b%0d_owner", b), own_q[b], exp_own[b]);
        chk($sformatf("stream_b%0d_len", b), len_q[b], exp_len[b]);
      end
    end
    chk("stream_tail_abort_count", n_ab, 32'd1);

    // Stall timeout (rr=2): owner 2 writes one beat, then drops valid for 16 cycles.
    @(negedge clk);
    drive(4'b0101, 4'b0000, 1'b1, 5'd16, 700);
    #1;
    chk("to_idle_gv", {31'd0, grant_valid}, 32'd0);
    @(negedge clk);
    drive(4'b0101, 4'b0000, 1'b1, 5'd16, 701);
    #1;
    chk("to_beat_en", {31'd0, fifo_wr_en}, 32'd1);
    chk("to_beat_gid", {30'd0, grant_id}, 32'd2);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(4'b0001, 4'b0000, 1'b1, 5'd16, 710 + i);
      #1;
      chk($sformatf("to_stall%0d_abort", i + 1), {31'd0, abort}, {31'd0, (i == 15)});
      chk($sformatf("to_stall%0d_gv", i + 1), {31'd0, grant_valid}, 32'd1);
    end
    @(negedge clk);
    drive(4'b0001, 4'b0000, 1'b1, 5'd16, 730);
    #1;
    chk("to_after_gv", {31'd0, grant_valid}, 32'd0);
    chk("to_after_abort", {31'd0, abort}, 32'd0);
    @(negedge clk);
    drive(4'b0001, 4'b0001, 1'b1, 5'd16, 731);
    #1;
    chk("to_next_gv", {31'd0, grant_valid}, 32'd1);
    chk("to_next_gid", {30'd0, grant_id}, 32'd0);
    chk("to_next_en", {31'd0, fifo_wr_en}, 32'd1);

    // FIFO full for 40 cycles with owner 1 valid: grant held, no beat, no abort (rr=1).
    @(negedge clk);
    drive(4'b0010, 4'b0000, 1'b0, 5'd16, 740);
    n_ab = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(4'b0010, 4'b0000, 1'b0, 5'd16, 741 + i);
      #1;
      n_ab = n_ab + int'(abort) + int'(fifo_wr_en);
      chk($sformatf("full%0d_gv", i), {31'd0, grant_valid}, 32'd1);
    end
    chk("full_no_abort_no_beat", n_ab, 32'd0);
    chk("full_gid", {30'd0, grant_id}, 32'd1);
    @(negedge clk);
    drive(4'b0010, 4'b0010, 1'b1, 5'd16, 790);
    #1;
    chk("full_release_en", {31'd0, fifo_wr_en}, 32'd1);
    chk("full_release_ready", {28'd0, req_ready}, 32'h2);

    // Asynchronous reset in the middle of a burst (rr=2, only req 1 valid).
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(4'b0010, 4'b0000, 1'b1, 5'd16, 800 + i);
      #1;
      if (grant_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_grant_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #3;
    chk("rst_pre_en", {31'd0, fifo_wr_en}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 5'd16, 850);
    repeat (3) @(negedge clk);
    #1;
    check_idle("rst_release");
    @(negedge clk);
    drive(4'b1111, 4'b0000, 1'b1, 5'd16, 860);
    #1;
    chk("rst_first_idle_gv", {31'd0, grant_valid}, 32'd0);
    @(negedge clk);
    drive(4'b1111, 4'b1111, 1'b1, 5'd16, 861);
    #1;
    chk("rst_first_gv", {31'd0, grant_valid}, 32'd1);
    chk("rst_first_gid", {30'd0, grant_id}, 32'd0);
    chk("rst_first_en", {31'd0, fifo_wr_en}, 32'd1);
    chk("rst_first_data", fifo_wr_data, exp_data(1'b1, 2'd0, 861));
    @(negedge clk);
    drive(4'b0000, 4'b0000, 1'b1, 5'd16, 862);
    #1;
    check_idle("rst_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
